// File: rtl/axi_bus_wr_mem_slave.sv
// AXI write-channel slave that streams accepted W beats straight onto a simple
// memory write port, one outstanding burst at a time (IDLE -> DATA -> RESP).
module axi_bus_wr_mem_slave #(
  parameter int ID_WIDTH = 2,
  parameter int MEM_AW   = 16
) (
  input  logic                B_CLK,
  input  logic                BUS_RSTN_SYNC,
  // AW channel
  input  logic [ID_WIDTH-1:0] WR_ADDR_ID,
  input  logic [31:0]         WR_ADDR,
  input  logic [7:0]          WR_ADDR_LEN,
  input  logic [1:0]          WR_ADDR_BURST,
  input  logic                WR_ADDR_VALID,
  output logic                WR_ADDR_READY,
  // W channel
  input  logic [31:0]         WR_DATA,
  input  logic [3:0]          WR_STRB,
  input  logic                WR_DATA_LAST,
  input  logic                WR_DATA_VALID,
  output logic                WR_DATA_READY,
  // B channel
  output logic [ID_WIDTH-1:0] WR_BACK_ID,
  output logic [1:0]          WR_BACK_RESP,
  output logic                WR_BACK_VALID,
  input  logic                WR_BACK_READY,
  // memory write port
  output logic                MEM_WR_EN,
  output logic [MEM_AW-1:0]   MEM_ADDR,
  output logic [31:0]         MEM_WDATA,
  output logic [3:0]          MEM_STRB,
  input  logic                MEM_READY,
  // current FSM state, for observation only
  output logic [1:0]          dbg_state_o
);

  // Handshakes: a transfer happens on the rising B_CLK edge where VALID and
  // READY are both high; VALID never waits on READY, payload holds while VALID.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                aw_rdy_q, aw_rdy_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [31:0]         addr_q, addr_d;
  logic [7:0]          len_q, len_d;
  logic [1:0]          burst_q, burst_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                over_q, over_d;

  logic                aw_hs;
  logic                w_hs;
  logic                wrap_len_ok;
  logic                aw_wrap_len_ok;
  logic [31:0]         incr_addr;
  logic [31:0]         wrap_mask;
  logic [31:0]         next_addr;

  assign aw_hs          = WR_ADDR_VALID & aw_rdy_q;
  assign w_hs           = WR_DATA_VALID & WR_DATA_READY;
  assign wrap_len_ok    = (len_q == 8'd1) | (len_q == 8'd3) | (len_q == 8'd7) | (len_q == 8'd15);
  assign aw_wrap_len_ok = (WR_ADDR_LEN == 8'd1) | (WR_ADDR_LEN == 8'd3) |
                          (WR_ADDR_LEN == 8'd7) | (WR_ADDR_LEN == 8'd15);
  assign incr_addr      = addr_q + 32'd4;
  // Window size minus one is LEN*4+3 for the legal wrap lengths.
  assign wrap_mask      = {22'd0, len_q, 2'b11};

  always_comb begin
    next_addr = incr_addr;
    case (burst_q)
      2'b00:   next_addr = addr_q;
      2'b10:   if (wrap_len_ok) next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
      default: next_addr = incr_addr;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    id_d          = id_q;
    addr_d        = addr_q;
    len_d         = len_q;
    burst_d       = burst_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    over_d        = over_q;
    WR_DATA_READY = 1'b0;
    MEM_WR_EN     = 1'b0;
    WR_BACK_VALID = 1'b0;
    WR_BACK_ID    = '0;
    WR_BACK_RESP  = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (aw_hs) begin
          id_d    = WR_ADDR_ID;
          addr_d  = WR_ADDR;
          len_d   = WR_ADDR_LEN;
          burst_d = WR_ADDR_BURST;
          cnt_d   = 8'd0;
          over_d  = 1'b0;
          // Reserved burst or illegal wrap length is known up front.
          err_d   = (WR_ADDR_BURST == 2'b11) |
                    ((WR_ADDR_BURST == 2'b10) & ~aw_wrap_len_ok);
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        // Overrun beats are drained without waiting on the memory.
        WR_DATA_READY = over_q | MEM_READY;
        if (w_hs) begin
          MEM_WR_EN = ~over_q;
          cnt_d     = cnt_q + 8'd1;
          addr_d    = next_addr;
          if (WR_DATA_LAST) begin
            if (!over_q && (cnt_q != len_q)) err_d = 1'b1;
            state_d = S_RESP;
          end else if (!over_q && (cnt_q == len_q)) begin
            err_d  = 1'b1;
            over_d = 1'b1;
          end
        end
      end
      S_RESP: begin
        WR_BACK_VALID = 1'b1;
        WR_BACK_ID    = id_q;
        WR_BACK_RESP  = err_q ? 2'b10 : 2'b00;
        if (WR_BACK_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    aw_rdy_d = (state_d == S_IDLE);
  end

  always_ff @(posedge B_CLK or negedge BUS_RSTN_SYNC) begin
    if (!BUS_RSTN_SYNC) begin
      state_q  <= S_IDLE;
      aw_rdy_q <= 1'b0;
      id_q     <= '0;
      addr_q   <= 32'd0;
      len_q    <= 8'd0;
      burst_q  <= 2'b00;
      cnt_q    <= 8'd0;
      err_q    <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      aw_rdy_q <= aw_rdy_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      burst_q  <= burst_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      over_q   <= over_d;
    end
  end

  assign WR_ADDR_READY = aw_rdy_q;
  assign MEM_ADDR      = {addr_q[MEM_AW-1:2], 2'b00};
  assign MEM_WDATA     = MEM_WR_EN ? WR_DATA : 32'd0;
  assign MEM_STRB      = MEM_WR_EN ? WR_STRB : 4'd0;
  assign dbg_state_o   = state_q;

endmodule
